// File: rtl/spi_pkg.sv
// Shared types and helpers for the byte-oriented SPI slave.
package spi_pkg;

  localparam int SPI_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  function automatic logic spi_cpol(input int mode);
    return mode[1];
  endfunction

  function automatic logic spi_cpha(input int mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Sync,
  output logic o_Rise,
  output logic o_Fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_reg <= {STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], i_Async};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign o_Sync = sync_reg[STAGES-1];
  assign o_Rise = sync_reg[STAGES-1] & ~prev_reg;
  assign o_Fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI slave, all four modes, oversampled on the system clock; exchanges one
// byte per 8 SPI clocks with a single-entry TX holding register.
module spi_slave_byte
  import spi_pkg::*;
#(
  parameter int SPI_MODE    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_SPI_Clk,
  input  logic                i_SPI_CS_n,
  input  logic                i_SPI_MOSI,
  output logic                o_SPI_MISO,
  output logic                o_SPI_MISO_En,
  input  logic [SPI_BITS-1:0] i_TX_Byte,
  input  logic                i_TX_DV,
  output logic                o_TX_Ready,
  output logic                o_RX_DV,
  output logic [SPI_BITS-1:0] o_RX_Byte,
  output logic                o_TX_Underrun
);

  localparam logic CPOL   = spi_cpol(SPI_MODE);
  localparam logic CPHA   = spi_cpha(SPI_MODE);
  localparam int   SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise_unused, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(CPOL)) u_sync_sclk (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_Clk),
    .o_Sync(sclk_sync_unused), .o_Rise(sclk_rise), .o_Fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_cs (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_CS_n),
    .o_Sync(cs_sync), .o_Rise(cs_rise_unused), .o_Fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_MOSI),
    .o_Sync(mosi_sync), .o_Rise(mosi_rise_unused), .o_Fall(mosi_fall_unused)
  );

  logic leading_edge, trailing_edge, sample_edge, shift_edge;

  assign leading_edge  = CPOL ? sclk_fall : sclk_rise;
  assign trailing_edge = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge   = CPHA ? trailing_edge : leading_edge;
  assign shift_edge    = CPHA ? leading_edge  : trailing_edge;

  spi_state_t          state_reg;
  logic [2:0]          bit_cnt_reg;
  logic [SPI_BITS-1:0] tx_shift_reg, rx_shift_reg, hold_reg, rx_byte_reg;
  logic                hold_full_reg, skip_shift_reg, underrun_pend_reg;
  logic                rx_dv_reg, underrun_reg;
  logic [SPI_BITS-1:0] rx_next;

  assign rx_next = {rx_shift_reg[SPI_BITS-2:0], mosi_sync};

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg         <= IDLE;
      bit_cnt_reg       <= '0;
      tx_shift_reg      <= '0;
      rx_shift_reg      <= '0;
      hold_reg          <= '0;
      hold_full_reg     <= 1'b0;
      rx_byte_reg       <= '0;
      rx_dv_reg         <= 1'b0;
      underrun_reg      <= 1'b0;
      underrun_pend_reg <= 1'b0;
      skip_shift_reg    <= 1'b0;
    end else begin
      rx_dv_reg    <= 1'b0;
      underrun_reg <= 1'b0;

      if (cs_sync) begin
        state_reg         <= IDLE;
        bit_cnt_reg       <= '0;
        rx_shift_reg      <= '0;
        tx_shift_reg      <= '0;
        underrun_pend_reg <= 1'b0;
        skip_shift_reg    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cs_fall) state_reg <= LOAD;
          end
          LOAD: begin
            tx_shift_reg      <= hold_full_reg ? hold_reg : '0;
            underrun_reg      <= ~hold_full_reg;
            hold_full_reg     <= 1'b0;
            bit_cnt_reg       <= '0;
            underrun_pend_reg <= 1'b0;
            // With CPHA=1 bit 7 is already on MISO, so the first leading edge must not shift.
            skip_shift_reg    <= CPHA;
            state_reg         <= SHIFT;
          end
          SHIFT: begin
            // A reload from an empty holding register only counts as an underrun
            // once the next byte actually starts.
            if (leading_edge && underrun_pend_reg) begin
              underrun_reg      <= 1'b1;
              underrun_pend_reg <= 1'b0;
            end
            if (shift_edge) begin
              if (skip_shift_reg) skip_shift_reg <= 1'b0;
              else tx_shift_reg <= {tx_shift_reg[SPI_BITS-2:0], 1'b0};
            end
            if (sample_edge) begin
              rx_shift_reg <= rx_next;
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'(SPI_BITS - 1)) begin
                rx_byte_reg       <= rx_next;
                rx_dv_reg         <= 1'b1;
                tx_shift_reg      <= hold_full_reg ? hold_reg : '0;
                underrun_pend_reg <= ~hold_full_reg;
                hold_full_reg     <= 1'b0;
                skip_shift_reg    <= 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end

      // Placed last so a write in the same cycle as a transfer lands after it.
      if (i_TX_DV && !hold_full_reg) begin
        hold_reg      <= i_TX_Byte;
        hold_full_reg <= 1'b1;
      end
    end
  end

  assign o_SPI_MISO_En = (state_reg != IDLE);
  assign o_SPI_MISO    = o_SPI_MISO_En & tx_shift_reg[SPI_BITS-1];
  assign o_TX_Ready    = ~hold_full_reg;
  assign o_RX_DV       = rx_dv_reg;
  assign o_RX_Byte     = rx_byte_reg;
  assign o_TX_Underrun = underrun_reg;

endmodule

// File: doc/spi_slave_byte.md
SPI_SLAVE_BYTE -- requirements
Module: spi_slave_byte

Interface
REQ-001 The block SHALL provide parameter SPI_MODE, default 3, setting CPOL = SPI_MODE[1] and CPHA = SPI_MODE[0].
REQ-002 The block SHALL provide parameter SYNC_STAGES, default 2, setting the flop count of each input synchronizer (minimum 2).
REQ-003 The block SHALL provide port i_Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL provide port i_Rst, input, 1 bit: reset, synchronous to i_Clk and active-high.
REQ-005 The block SHALL provide port i_SPI_Clk, input, 1 bit: SPI clock from the master, asynchronous to i_Clk.
REQ-006 The block SHALL provide port i_SPI_CS_n, input, 1 bit: active-low chip select, asynchronous.
REQ-007 The block SHALL provide port i_SPI_MOSI, input, 1 bit: serial data from the master.
REQ-008 The block SHALL provide port o_SPI_MISO, output, 1 bit: serial data to the master.
REQ-009 The block SHALL provide port o_SPI_MISO_En, output, 1 bit: MISO drive enable for the pad tri-state.
REQ-010 The block SHALL provide port i_TX_Byte, input, 8 bits: next byte to send.
REQ-011 The block SHALL provide port i_TX_DV, input, 1 bit: i_TX_Byte valid.
REQ-012 The block SHALL provide port o_TX_Ready, output, 1 bit: TX holding register empty.
REQ-013 The block SHALL provide port o_RX_DV, output, 1 bit: one-cycle pulse, o_RX_Byte valid.
REQ-014 The block SHALL provide port o_RX_Byte, output, 8 bits: last complete received byte.
REQ-015 The block SHALL provide port o_TX_Underrun, output, 1 bit: one-cycle pulse, byte started with the holding register empty.

Function
REQ-016 i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI SHALL each pass through a SYNC_STAGES-deep synchronizer; edges SHALL be detected on the synchronized SPI clock.
REQ-017 The leading edge SHALL be rising when CPOL=0 and falling when CPOL=1; the trailing edge is the opposite.
REQ-018 The sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge is the other edge.
REQ-019 Data SHALL be MSB first in both directions, with 8 bits per byte and a 3-bit bit counter that wraps 7->0.
REQ-020 The FSM SHALL have states IDLE, LOAD and SHIFT.
REQ-021 IDLE SHALL be held while synced CS_n=1; synced CS_n falling SHALL move IDLE->LOAD.
REQ-022 LOAD SHALL last 1 cycle, copy the holding register into the TX shift register, clear the bit counter, and then move to SHIFT.
REQ-023 In SHIFT, the 8th sample SHALL set the bit counter to 0, reload the TX shift register from the holding register in the same cycle, and remain in SHIFT for back-to-back bytes.
REQ-024 Synced CS_n rising in any state SHALL move the FSM to IDLE, discard the partial RX byte, suppress o_RX_DV, and leave the holding register contents untouched.
REQ-025 o_SPI_MISO SHALL present the TX shift register MSB.
REQ-026 When CPHA=0, bit 7 SHALL be valid from LOAD onward; the shift register SHALL shift on each shift edge except the shift edge that follows the 8th sample.
REQ-027 o_SPI_MISO_En SHALL be 1 in LOAD and SHIFT and 0 in IDLE; o_SPI_MISO SHALL be 0 when o_SPI_MISO_En is 0.
REQ-028 On each sample edge, synced MOSI SHALL be shifted into the RX shift register.
REQ-029 o_RX_Byte SHALL update, and o_RX_DV SHALL pulse, exactly 1 i_Clk cycle after the i_Clk cycle in which the 8th sample edge is detected; o_RX_Byte SHALL hold until the next update.
REQ-030 i_TX_DV sampled with o_TX_Ready=1 SHALL write the holding register and drive o_TX_Ready low from the next cycle; i_TX_DV with o_TX_Ready=0 SHALL be ignored.
REQ-031 A holding->shift transfer SHALL set o_TX_Ready high on the next cycle.
REQ-032 If i_TX_DV and a transfer occur in the same cycle, the transfer SHALL take the old contents and the new byte SHALL be written to the holding register.
REQ-033 A transfer with the holding register empty SHALL load 8'h00 into the TX shift register and pulse o_TX_Underrun.
REQ-034 Correct operation SHALL be guaranteed for SPI clock half periods of at least SYNC_STAGES+2 i_Clk cycles and a CS_n setup of at least 2 half periods.

Reset
REQ-035 i_Rst=1 at a rising edge of i_Clk SHALL put the FSM in IDLE and clear both shift registers, the holding register and the bit counter.
REQ-036 Reset values SHALL be: o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0, o_SPI_MISO=0, o_SPI_MISO_En=0, o_TX_Underrun=0.
REQ-037 Synchronizer flops SHALL reset to the idle levels: CS_n=1, SPI clock=CPOL, MOSI=0.
REQ-038 A reset asserted mid-byte SHALL abort the byte, and no o_RX_DV pulse SHALL be produced for it.

Structure
REQ-039 Package spi_pkg SHALL hold the spi_state_t enum (IDLE, LOAD, SHIFT), SPI_BITS=8, and the CPOL/CPHA extraction helper functions.
REQ-040 Sub-module spi_sync_edge (synchronizer, rise/fall pulses) SHALL be instantiated once per SPI clock, CS_n and MOSI, with edge outputs unused for MOSI.

Verification
REQ-041 Mode 3, master CLKS_PER_HALF_BIT=4, slave preloaded with 0x3C, master sends 0xC1 -> o_RX_Byte=0xC1 with one o_RX_DV pulse, and the master receives 0x3C.
REQ-042 Mode 0, back-to-back 0xBE then 0xEF under one CS, slave preloaded with 0x5A then 0xA5 (second byte written after o_TX_Ready rises) -> two o_RX_DV pulses with 0xBE and 0xEF, the master receives 0x5A and 0xA5, and o_TX_Underrun stays 0.
REQ-043 Modes 1 and 2, send 0x81 with slave byte 0x7E -> both directions are correct in each mode.
REQ-044 Master sends with no i_TX_DV issued -> the master receives 0x00, o_TX_Underrun pulses once, and RX is still correct.
REQ-045 CS_n raised after 4 bits, then a full byte 0x96 is sent -> no o_RX_DV for the partial byte, then o_RX_Byte=0x96, with MISO_En=0 while CS_n is high.
REQ-046 i_Rst asserted for 1 cycle mid-byte -> all outputs take their REQ-036 reset values and no o_RX_DV pulse occurs; the next full byte 0x42 is received correctly.
